kt8_alu_seq: RTL and testbench

Sequencer driving the other side of the kt8 8-bit ALU interface. Accepts 16-bit instructions over a valid/ready handshake and reads operands from a 4×8 register file. It presents opcode and operands to the external combinational ALU, captures the result and writes it back. It then returns the result with Z/N flags over a second valid/ready handshake. It sits between the kt8 instruction source and the ALU, which is instantiated alongside it at the top level.

---
 rtl/kt8_pkg.sv | 37 +++
 rtl/kt8_alu_seq_if.sv | 34 +++
 rtl/kt8_regfile.sv | 29 ++
 rtl/kt8_alu_seq.sv | 122 ++++++++++++
 tb/tb_kt8_alu_seq.sv | 205 ++++++++++++++++++++
 5 files changed

// File: rtl/kt8_pkg.sv
// kt8 sequencer shared definitions.
// Opcodes, instruction field positions, FSM states.
package kt8_pkg;

  localparam logic [3:0] OP_ADD   = 4'd0;
  localparam logic [3:0] OP_SUB   = 4'd1;
  localparam logic [3:0] OP_AND   = 4'd2;
  localparam logic [3:0] OP_OR    = 4'd3;
  localparam logic [3:0] OP_XOR   = 4'd4;
  localparam logic [3:0] OP_NOTA  = 4'd5;
  localparam logic [3:0] OP_NOTB  = 4'd6;
  localparam logic [3:0] OP_PASSA = 4'd7;
  localparam logic [3:0] OP_PASSB = 4'd8;
  localparam logic [3:0] OP_SHL   = 4'd9;
  localparam logic [3:0] OP_SHR   = 4'd10;
  localparam logic [3:0] OP_ZERO  = 4'd11;
  localparam logic [3:0] OP_INC   = 4'd12;
  localparam logic [3:0] OP_DEC   = 4'd13;
  localparam logic [3:0] OP_LDI   = 4'd14;
  localparam logic [3:0] OP_OUT   = 4'd15;

  localparam int OP_MSB  = 15;
  localparam int OP_LSB  = 12;
  localparam int RD_MSB  = 11;
  localparam int RD_LSB  = 10;
  localparam int RS_MSB  = 9;
  localparam int RS_LSB  = 8;
  localparam int IMM_MSB = 7;
  localparam int IMM_LSB = 0;

  typedef enum logic [1:0] {
    IDLE,
    EXEC,
    RESP
  } state_t;

endpackage

// File: rtl/kt8_alu_seq_if.sv
// kt8 sequencer bus: instruction in, ALU drive,
// result out. slave = sequencer side.
interface kt8_alu_seq_if;
  logic        instr_valid_i;
  logic        instr_ready_o;
  logic [15:0] instr_i;
  logic [3:0]  alu_op_o;
  logic [7:0]  alu_a_o;
  logic [7:0]  alu_b_o;
  logic [7:0]  alu_r_i;
  logic        res_valid_o;
  logic        res_ready_i;
  logic [7:0]  res_data_o;
  logic        res_z_o;
  logic        res_n_o;

  modport slave (
    input  instr_valid_i, instr_i,
    input  alu_r_i, res_ready_i,
    output instr_ready_o,
    output alu_op_o, alu_a_o, alu_b_o,
    output res_valid_o, res_data_o,
    output res_z_o, res_n_o
  );

  modport master (
    output instr_valid_i, instr_i,
    output alu_r_i, res_ready_i,
    input  instr_ready_o,
    input  alu_op_o, alu_a_o, alu_b_o,
    input  res_valid_o, res_data_o,
    input  res_z_o, res_n_o
  );
endinterface

// File: rtl/kt8_regfile.sv
// kt8 4x8 register file: two async reads,
// one sync write, async clear.
module kt8_regfile (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       i_we,
  input  logic [1:0] i_waddr,
  input  logic [7:0] i_wdata,
  input  logic [1:0] i_raddr_a,
  input  logic [1:0] i_raddr_b,
  output logic [7:0] o_rdata_a,
  output logic [7:0] o_rdata_b
);

  logic [7:0] r_mem [4];

  // write port; reset clears every entry
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < 4; i++) r_mem[i] <= '0;
    end else if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  assign o_rdata_a = r_mem[i_raddr_a];
  assign o_rdata_b = r_mem[i_raddr_b];

endmodule

// File: rtl/kt8_alu_seq.sv
// kt8 ALU sequencer: decode, drive external ALU,
// write back, return result with Z/N.
module kt8_alu_seq
  import kt8_pkg::*;
(
  input logic clk_i,
  input logic rst_ni,
  kt8_alu_seq_if.slave bus
);

  state_t     r_state;
  state_t     w_state_d;
  logic [3:0] r_op;
  logic [7:0] r_a;
  logic [7:0] r_b;
  logic [1:0] r_rd;
  logic       r_wb;
  logic [7:0] r_res;
  logic       r_z;
  logic       r_n;

  logic [3:0] w_op;
  logic [1:0] w_rd;
  logic [1:0] w_rs;
  logic [7:0] w_imm;
  logic [7:0] w_ra;
  logic [7:0] w_rb;
  logic [3:0] w_aop;
  logic [7:0] w_bsel;
  logic       w_acc;
  logic       w_we;

  assign w_op  = bus.instr_i[OP_MSB:OP_LSB];
  assign w_rd  = bus.instr_i[RD_MSB:RD_LSB];
  assign w_rs  = bus.instr_i[RS_MSB:RS_LSB];
  assign w_imm = bus.instr_i[IMM_MSB:IMM_LSB];
  assign w_acc = (r_state == IDLE) && bus.instr_valid_i;
  assign w_we  = (r_state == EXEC) && r_wb;

  kt8_regfile u_rf (
    .clk_i     (clk_i),
    .rst_ni    (rst_ni),
    .i_we      (w_we),
    .i_waddr   (r_rd),
    .i_wdata   (bus.alu_r_i),
    .i_raddr_a (w_rd),
    .i_raddr_b (w_rs),
    .o_rdata_a (w_ra),
    .o_rdata_b (w_rb)
  );

  // map LDI/OUT onto plain ALU pass operations
  always_comb begin
    w_aop  = w_op;
    w_bsel = w_rb;
    unique case (1'b1)
      (w_op == OP_LDI): begin
        w_aop  = OP_PASSB;
        w_bsel = w_imm;
      end
      (w_op == OP_OUT): w_aop = OP_PASSA;
      default: ;
    endcase
  end

  // state register
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) r_state <= IDLE;
    else         r_state <= w_state_d;
  end

  // next-state logic
  always_comb begin
    w_state_d = r_state;
    unique case (r_state)
      IDLE:    if (w_acc) w_state_d = EXEC;
      EXEC:    w_state_d = RESP;
      RESP:    if (bus.res_ready_i) w_state_d = IDLE;
      default: w_state_d = IDLE;
    endcase
  end

  // ALU drive registers, loaded on accept only
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_op <= OP_ZERO;
      r_a  <= '0;
      r_b  <= '0;
      r_rd <= '0;
      r_wb <= 1'b0;
    end else if (w_acc) begin
      r_op <= w_aop;
      r_a  <= w_ra;
      r_b  <= w_bsel;
      r_rd <= w_rd;
      r_wb <= (w_op != OP_OUT);
    end
  end

  // result capture at end of EXEC, held through RESP
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_res <= '0;
      r_z   <= 1'b0;
      r_n   <= 1'b0;
    end else if (r_state == EXEC) begin
      r_res <= bus.alu_r_i;
      r_z   <= (bus.alu_r_i == 8'd0);
      r_n   <= bus.alu_r_i[7];
    end
  end

  assign bus.instr_ready_o = (r_state == IDLE);
  assign bus.res_valid_o   = (r_state == RESP);
  assign bus.alu_op_o      = r_op;
  assign bus.alu_a_o       = r_a;
  assign bus.alu_b_o       = r_b;
  assign bus.res_data_o    = r_res;
  assign bus.res_z_o       = r_z;
  assign bus.res_n_o       = r_n;

endmodule

// File: tb/tb_kt8_alu_seq.sv
// kt8_alu_seq bench: directed + random instructions
// against an instruction-level register model.
module tb_kt8_alu_seq;

  logic clk = 1'b0;
  logic rst_n;
  int   checks = 0;
  int   errors = 0;
  logic [7:0] m [4];

  always #5 clk = ~clk;

  kt8_alu_seq_if bus ();

  kt8_alu_seq dut (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .bus    (bus)
  );

  function automatic logic [7:0] alu_f(
    input logic [3:0] op,
    input logic [7:0] a,
    input logic [7:0] b
  );
    case (op)
      4'd0:    return a + b;
      4'd1:    return a - b;
      4'd2:    return a & b;
      4'd3:    return a | b;
      4'd4:    return a ^ b;
      4'd5:    return ~a;
      4'd6:    return ~b;
      4'd7:    return a;
      4'd8:    return b;
      4'd9:    return {a[6:0], 1'b0};
      4'd10:   return {1'b0, a[7:1]};
      4'd11:   return 8'd0;
      4'd12:   return a + 8'd1;
      4'd13:   return a - 8'd1;
      default: return 8'd0;
    endcase
  endfunction

  always_comb
    bus.alu_r_i = alu_f(bus.alu_op_o, bus.alu_a_o, bus.alu_b_o);

  task automatic check(
    input string       tag,
    input logic [31:0] obs,
    input logic [31:0] exp
  );
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_clear();
    for (int i = 0; i < 4; i++) m[i] = 8'd0;
  endtask

  // run one instruction; stall>0 holds res_ready low that many cycles
  task automatic do_instr(input logic [15:0] ins, input int stall);
    logic [3:0] op;
    logic [1:0] rd;
    logic [1:0] rs;
    logic [7:0] imm;
    logic [7:0] ra;
    logic [7:0] rb;
    logic [7:0] e;
    logic [3:0] eop;
    int n;
    op  = ins[15:12];
    rd  = ins[11:10];
    rs  = ins[9:8];
    imm = ins[7:0];
    ra  = m[rd];
    rb  = m[rs];
    case (op)
      4'd0:  e = ra + rb;
      4'd1:  e = ra - rb;
      4'd2:  e = ra & rb;
      4'd3:  e = ra | rb;
      4'd4:  e = ra ^ rb;
      4'd5:  e = ~ra;
      4'd6:  e = ~rb;
      4'd7:  e = ra;
      4'd8:  e = rb;
      4'd9:  e = ra << 1;
      4'd10: e = ra >> 1;
      4'd11: e = 8'd0;
      4'd12: e = ra + 8'd1;
      4'd13: e = ra - 8'd1;
      4'd14: e = imm;
      default: e = ra;
    endcase
    eop = (op == 4'd14) ? 4'd8 : (op == 4'd15) ? 4'd7 : op;
    bus.instr_i = ins;
    bus.instr_valid_i = 1'b1;
    n = 0;
    while (!bus.instr_ready_o && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    check("accept_ready", bus.instr_ready_o, 1);
    @(posedge clk); #1;
    bus.instr_valid_i = 1'b0;
    check("exec_valid", bus.res_valid_o, 0);
    check("exec_rdy", bus.instr_ready_o, 0);
    check("exec_op", bus.alu_op_o, eop);
    check("exec_a", bus.alu_a_o, ra);
    check("exec_b", bus.alu_b_o, (op == 4'd14) ? imm : rb);
    bus.res_ready_i = (stall == 0);
    @(posedge clk); #1;
    check("resp_valid", bus.res_valid_o, 1);
    check("resp_data", bus.res_data_o, e);
    check("resp_z", bus.res_z_o, (e == 8'd0));
    check("resp_n", bus.res_n_o, e[7]);
    if (op != 4'd15) m[rd] = e;
    if (stall > 0) begin
      bus.instr_valid_i = 1'b1;
      bus.instr_i = 16'($urandom);
      repeat (stall) begin
        @(posedge clk); #1;
        check("bp_valid", bus.res_valid_o, 1);
        check("bp_data", bus.res_data_o, e);
        check("bp_rdy", bus.instr_ready_o, 0);
      end
      bus.instr_valid_i = 1'b0;
      bus.res_ready_i = 1'b1;
    end
    @(posedge clk); #1;
    check("done_rdy", bus.instr_ready_o, 1);
    check("done_valid", bus.res_valid_o, 0);
  endtask

  initial begin
    rst_n = 1'b0;
    bus.instr_valid_i = 1'b0;
    bus.instr_i = 16'h0;
    bus.res_ready_i = 1'b1;
    model_clear();
    #12;
    check("rst_rdy", bus.instr_ready_o, 1);
    check("rst_valid", bus.res_valid_o, 0);
    check("rst_op", bus.alu_op_o, 11);
    check("rst_a", bus.alu_a_o, 0);
    check("rst_b", bus.alu_b_o, 0);
    check("rst_data", bus.res_data_o, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    do_instr(16'hE43C, 0);
    do_instr(16'hE8C4, 0);
    do_instr(16'h0600, 0);
    check("add_wrap_z", bus.res_z_o, 1);
    do_instr(16'hF400, 0);

    do_instr(16'hEC80, 0);
    do_instr(16'hFC00, 0);
    check("out_n", bus.res_n_o, 1);
    do_instr(16'hF400, 0);
    do_instr(16'hF800, 0);

    do_instr(16'hE420, 5);
    do_instr(16'hE805, 0);
    do_instr(16'h1A00, 0);
    do_instr(16'hD000, 0);
    check("dec_n", bus.res_data_o, 8'hFF);

    bus.instr_i = 16'hE455;
    bus.instr_valid_i = 1'b1;
    @(posedge clk); #1;
    bus.instr_valid_i = 1'b0;
    check("mid_exec", bus.instr_ready_o, 0);
    rst_n = 1'b0;
    #1;
    model_clear();
    check("mid_rst_rdy", bus.instr_ready_o, 1);
    check("mid_rst_valid", bus.res_valid_o, 0);
    check("mid_rst_op", bus.alu_op_o, 11);
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (3) begin
      @(posedge clk); #1;
      check("post_rst_valid", bus.res_valid_o, 0);
    end
    do_instr(16'hF400, 0);

    for (int k = 0; k < 60; k++) begin
      int s;
      s = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 4)) : 0;
      do_instr(16'($urandom), s);
    end
    for (int k = 0; k < 4; k++)
      do_instr({4'hF, 2'(k), 10'h0}, 0);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
